aes_128_round_sched: RTL
========================

# aes_128_round_sched

Iterative round scheduler for the AES-128 encryption path. Accepts one plaintext block and key through a valid/ready handshake, performs the initial AddRoundKey, then sequences an external single-round datapath (`one_round`-style combinational round plus key-step) ten times. It presents the ciphertext through a second valid/ready handshake. It replaces the fully unrolled pipeline where area matters more than throughput.

## Interface
- `NROUNDS`, default 10: round count. Fixed at 10 for AES-128; only a width sanity check uses it.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  block offered.
- `in_ready`  out  1  scheduler can accept.
- `in_key`  in  128  cipher key.
- `in_state`  in  128  plaintext.
- `out_valid`  out  1  ciphertext available.
- `out_ready`  in  1  consumer takes ciphertext.
- `out_data`  out  128  ciphertext.
- `busy`  out  1  a block is in flight (ROUND or DONE).
- `rd_state_o`  out  128  state to round datapath.
- `rd_key_o`  out  128  previous round key to datapath.
- `rd_rcon_o`  out  8  round constant for this round.
- `rd_last_o`  out  1  final round; datapath skips MixColumns.
- `rd_state_i`  in  128  datapath result state, combinational.
- `rd_key_i`  in  128  datapath next round key, combinational.

## Operation
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid&in_ready`: `st`<=`in_state^in_key`, `key`<=`in_key`, `rnd`<=1, go to ROUND.
- ROUND:
  - Drives `rd_state_o`=`st`, `rd_key_o`=`key`, `rd_rcon_o`=RCON[`rnd`], `rd_last_o`=(`rnd`==10).
  - Each cycle: `st`<=`rd_state_i`, `key`<=`rd_key_i`, `rnd`<=`rnd`+1.
  - When `rnd`==10, go to DONE.
- DONE:
  - `out_valid`=1, `out_data`=`st`.
  - Hold state and data stable until `out_ready`, then go to IDLE.
- RCON[1..10] = 01,02,04,08,10,20,40,80,1b,36. `rnd` is 4 bits. Values 0 and 11..15 are unreachable and drive `rd_rcon_o`=00.
- Outside ROUND: `rd_*_o` keep driving the `st`/`key` registers, `rd_last_o`=0, `rd_rcon_o`=00.
- `in_ready` is 0 in ROUND and DONE. Offers there are ignored, and the offering side must hold them.
- `out_valid` deasserts only after the handshake. `out_data` must not change while `out_valid`=1 and `out_ready`=0.
- `rst` in any state, including mid-round:
  - Next state IDLE; `st`, `key`, `rnd` cleared.
  - The in-flight block is dropped silently.
  - `rst` has priority over a simultaneous handshake.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `out_data`=0, `rd_state_o`=0, `rd_key_o`=0, `rd_rcon_o`=00, `rd_last_o`=0.
- Input handshake in cycle t. ROUND occupies cycles t+1..t+10. `out_valid` rises at t+11.
- With `out_ready` held high, the ciphertext is taken at t+11. Next acceptance is at t+12 without the macro, t+11 with it.
- Throughput: one block per 12 cycles (base), per 11 cycles (back-to-back).
- The datapath path `rd_*_o` -> `rd_*_i` is a single-cycle combinational path. The scheduler adds no logic after `rd_state_i`/`rd_key_i` other than the register mux.

## Configuration
- `AES_SCHED_BACK2BACK_EN` defined:
  - `in_ready` = IDLE | (DONE & `out_ready`).
  - An input handshake in the DONE cycle that completes output loads the new block and goes straight to ROUND.
- Undefined: `in_ready` = IDLE only.
- Port list is identical either way.

## Structure
- Shared package `aes_pkg` holds:
  - state enum `aes_sched_state_t` (IDLE, ROUND, DONE);
  - `AES_NROUNDS`=10;
  - `AES_RCON` 8-bit constant array indexed 1..10;
  - 128-bit block typedef `aes_block_t`.
- One natural sub-module, `aes_rcon_lut`: 4-bit `rnd` -> 8-bit rcon, combinational, 00 for out-of-range indices.
- The round datapath stays outside. The bench instantiates the team's existing round + key-step logic on the `rd_*` ports.

## Test plan
- FIPS-197 C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff.
  - Response: `out_data`=69c4e0d86a7b0430d8cdb78070b4c55a, `out_valid` exactly 11 cycles after accept.
- Rcon/last sequence: monitor `rd_rcon_o` over the ROUND cycles. It must read 01,02,04,08,10,20,40,80,1b,36, with `rd_last_o`=1 only on the 36 cycle.
- Output backpressure:
  - Stimulus: hold `out_ready`=0 for 5 cycles after `out_valid`.
  - Response: `out_data` and `out_valid` stable, `in_ready`=0, a second `in_valid` ignored; the block completes on the first `out_ready`=1.
- Reset mid-operation:
  - Stimulus: assert `rst` at round 5.
  - Response: next cycle `busy`=0, `in_ready`=1, `out_valid`=0. No output appears, and a fresh C.1 block then yields the correct ciphertext.
- Back-to-back, both builds: two C.1 blocks streamed with `out_ready`=1. Accept spacing is 12 cycles undefined, 11 with `AES_SCHED_BACK2BACK_EN`. Both outputs are correct.
- Simultaneous `rst` and `in_valid` in IDLE: the block is not accepted, and `busy` stays 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 types and constants for the round scheduler.
// Combinational only; no handshake of its own.
package aes_pkg;

    typedef logic [127:0] aes_block_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_sched_state_t;

    localparam int AES_NROUNDS = 10;

    localparam logic [1:10][7:0] AES_RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

endpackage

// File: rtl/aes_rcon_lut.sv
// Round number -> AES round constant, combinational, zero latency.
// Indices outside 1..AES_NROUNDS return 8'h00.
module aes_rcon_lut
    import aes_pkg::*;
(
    input  logic [3:0] rnd_i,
    output logic [7:0] rcon_o
);

    always_comb begin
        rcon_o = 8'h00;
        for (int i = 1; i <= AES_NROUNDS; i++) begin
            if (rnd_i == 4'(i)) begin
                rcon_o = AES_RCON[i];
            end
        end
    end

endmodule

// File: rtl/aes_128_round_sched.sv
// Iterative AES-128 round sequencer around an external one-round datapath; accept->out_valid is 11 cycles,
// output held until out_ready. AES_SCHED_BACK2BACK_EN lets a new block load in the output-handshake cycle.
module aes_128_round_sched
    import aes_pkg::*;
#(
    parameter int NROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_key,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [127:0] rd_state_o,
    output logic [127:0] rd_key_o,
    output logic [7:0]   rd_rcon_o,
    output logic         rd_last_o,
    input  logic [127:0] rd_state_i,
    input  logic [127:0] rd_key_i
);

    if (NROUNDS != AES_NROUNDS || NROUNDS > 15) begin : g_bad_nrounds
        $error("aes_128_round_sched: NROUNDS must be 10 and fit the 4-bit round counter");
    end

    localparam logic [3:0] LAST_RND = 4'(AES_NROUNDS);

    aes_sched_state_t state_q, state_d;
    aes_block_t       st_q, st_d;
    aes_block_t       key_q, key_d;
    logic [3:0]       rnd_q, rnd_d;
    logic [7:0]       lut_rcon;
    logic             accept;

    aes_rcon_lut u_rcon_lut (
        .rnd_i  (rnd_q),
        .rcon_o (lut_rcon)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            st_q    <= '0;
            key_q   <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
        end
    end

    assign accept = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    st_d    = in_state ^ in_key;
                    key_d   = in_key;
                    rnd_d   = 4'd1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                st_d  = rd_state_i;
                key_d = rd_key_i;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == LAST_RND) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
`ifdef AES_SCHED_BACK2BACK_EN
                    // Output drains and the next block loads on the same edge.
                    if (accept) begin
                        st_d    = in_state ^ in_key;
                        key_d   = in_key;
                        rnd_d   = 4'd1;
                        state_d = ROUND;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
`ifdef AES_SCHED_BACK2BACK_EN
        in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
`else
        in_ready  = (state_q == IDLE);
`endif
        out_valid  = (state_q == DONE);
        out_data   = st_q;
        busy       = (state_q == ROUND) | (state_q == DONE);
        rd_state_o = st_q;
        rd_key_o   = key_q;
        rd_rcon_o  = (state_q == ROUND) ? lut_rcon : 8'h00;
        rd_last_o  = (state_q == ROUND) & (rnd_q == LAST_RND);
    end

endmodule
